// File: rtl/mem_access_unit_if.sv
// Bus bundle between the memory-stage controller, the EX/MEM register,
// the data cache and the MEM/WB register.
interface mem_access_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             dREN_EX_MEM;
    logic             dWEN_EX_MEM;
    logic             datomic_EX_MEM;
    logic [31:0]      result_EX_MEM;
    logic [31:0]      dmemstore_EX_MEM;
    logic             stall_ext;
    logic             dhit;
    logic [31:0]      dmemload;
    logic             ccinv;
    logic [31:0]      ccsnoopaddr;
    logic             dmemREN;
    logic             dmemWEN;
    logic [31:0]      dmemaddr;
    logic [31:0]      dmemstore;
    logic [31:0]      dmemload_MEM;
    logic             stall_mem;
    logic             enable_MEM_WB;
    logic             flush_MEM_WB;
    logic             link_valid;
    logic [31:0]      link_addr;
    logic [CNT_W-1:0] mem_stall_cnt;

    modport slave (
        input  dREN_EX_MEM, dWEN_EX_MEM, datomic_EX_MEM, result_EX_MEM,
               dmemstore_EX_MEM, stall_ext, dhit, dmemload, ccinv, ccsnoopaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload_MEM, stall_mem,
               enable_MEM_WB, flush_MEM_WB, link_valid, link_addr, mem_stall_cnt
    );

    modport master (
        output dREN_EX_MEM, dWEN_EX_MEM, datomic_EX_MEM, result_EX_MEM,
               dmemstore_EX_MEM, stall_ext, dhit, dmemload, ccinv, ccsnoopaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload_MEM, stall_mem,
               enable_MEM_WB, flush_MEM_WB, link_valid, link_addr, mem_stall_cnt
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues cache requests until dhit, manages MEM/WB
// enable/flush and the upstream freeze, and owns the LL/SC link register.
module mem_access_unit #(
    parameter int unsigned CNT_W = 32
) (
    input logic              CLK,
    input logic              RST,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           r_state;
    logic             r_link_valid;
    logic [31:0]      r_link_addr;
    logic [31:0]      r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic        w_active;
    logic        w_link_hit;
    logic        w_snoop_hit;
    logic        w_sc;
    logic        w_sc_ok;
    logic        w_sc_fail;
    logic        w_req;
    logic        w_miss;
    logic        w_done;
    logic        w_link_set;
    logic        w_link_clr;
    logic [31:0] w_data;
    logic        w_unused;

    always_comb begin
        w_active    = (r_state != HOLD);
        w_link_hit  = r_link_valid & (bus.result_EX_MEM[31:2] == r_link_addr[31:2]);
        w_snoop_hit = bus.ccinv & (bus.ccsnoopaddr[31:2] == r_link_addr[31:2]);
        w_sc        = bus.dWEN_EX_MEM & bus.datomic_EX_MEM;
        w_sc_ok     = w_sc & w_link_hit;
        w_sc_fail   = w_sc & ~w_sc_ok;
        w_req       = (bus.dREN_EX_MEM | bus.dWEN_EX_MEM) & ~w_sc_fail;
        w_miss      = w_active & w_req & ~bus.dhit;
        w_done      = w_active & w_req & bus.dhit;
        w_link_set  = w_done & bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM & bus.datomic_EX_MEM;
        // A failed SC never reaches the cache, so it retires the link on its own.
        w_link_clr  = (w_done & bus.dWEN_EX_MEM & (bus.datomic_EX_MEM | w_link_hit))
                    | (w_active & w_sc_fail)
                    | w_snoop_hit;
        w_data      = '0;
        if (bus.dWEN_EX_MEM) begin
            w_data = {31'b0, w_sc_ok};
        end else if (bus.dREN_EX_MEM && bus.dhit) begin
            w_data = bus.dmemload;
        end
    end

    assign w_unused = ^bus.ccsnoopaddr[1:0];

    assign bus.dmemaddr      = bus.result_EX_MEM;
    assign bus.dmemstore     = bus.dmemstore_EX_MEM;
    assign bus.dmemREN       = ~RST & w_active & w_req & ~bus.dWEN_EX_MEM;
    assign bus.dmemWEN       = ~RST & w_active & w_req & bus.dWEN_EX_MEM;
    assign bus.stall_mem     = ~RST & w_miss;
    assign bus.flush_MEM_WB  = ~RST & w_miss;
    assign bus.enable_MEM_WB = ~RST & (w_miss | ~bus.stall_ext);
    assign bus.dmemload_MEM  = RST ? '0 : ((r_state == HOLD) ? r_hold : w_data);
    assign bus.link_valid    = r_link_valid;
    assign bus.link_addr     = r_link_addr;
    assign bus.mem_stall_cnt = r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            r_hold       <= '0;
            r_cnt        <= '0;
        end else begin
            assert (!(bus.dREN_EX_MEM && bus.dWEN_EX_MEM));

            if (w_miss && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_link_set) begin
                r_link_valid <= 1'b1;
                r_link_addr  <= bus.result_EX_MEM;
            end else if (w_link_clr) begin
                r_link_valid <= 1'b0;
            end

            case (r_state)
                IDLE, WAIT: begin
                    if (w_done) begin
                        if (bus.stall_ext) begin
                            r_hold  <= w_data;
                            r_state <= HOLD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_miss) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!bus.stall_ext) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hit/miss latency, LL/SC, snoop
// invalidation, external-stall hold, reset mid-miss and counter saturation.
module tb_mem_access_unit;
    logic CLK;
    logic RST;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit_if #(.CNT_W(32)) bus  ();
    mem_access_unit_if #(.CNT_W(4))  bus4 ();

    mem_access_unit #(.CNT_W(32)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));
    mem_access_unit #(.CNT_W(4))  u_sat (.CLK(CLK), .RST(RST), .bus(bus4));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dREN_EX_MEM = 0;  bus.dWEN_EX_MEM = 0;  bus.datomic_EX_MEM = 0;
        bus.result_EX_MEM = 0; bus.dmemstore_EX_MEM = 0; bus.stall_ext = 0;
        bus.dhit = 0; bus.dmemload = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
        bus4.dREN_EX_MEM = 0; bus4.dWEN_EX_MEM = 0; bus4.datomic_EX_MEM = 0;
        bus4.result_EX_MEM = 0; bus4.dmemstore_EX_MEM = 0; bus4.stall_ext = 0;
        bus4.dhit = 0; bus4.dmemload = 0; bus4.ccinv = 0; bus4.ccsnoopaddr = 0;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        bus.dREN_EX_MEM = 1; bus.result_EX_MEM = 32'h100;
        repeat (2) @(negedge CLK);
        #2;
        chk("rst_ren",    {31'b0, bus.dmemREN},       0);
        chk("rst_stall",  {31'b0, bus.stall_mem},     0);
        chk("rst_enable", {31'b0, bus.enable_MEM_WB}, 0);
        chk("rst_flush",  {31'b0, bus.flush_MEM_WB},  0);
        chk("rst_load",   bus.dmemload_MEM,           0);
        chk("rst_link",   {31'b0, bus.link_valid},    0);
        chk("rst_cnt",    bus.mem_stall_cnt,          0);

        @(negedge CLK); RST = 0; clear_inputs();

        // LW hit
        @(negedge CLK);
        bus.dREN_EX_MEM = 1; bus.result_EX_MEM = 32'h100; bus.dhit = 1; bus.dmemload = 32'hDEADBEEF;
        #2;
        chk("lw_ren",    {31'b0, bus.dmemREN},       1);
        chk("lw_stall",  {31'b0, bus.stall_mem},     0);
        chk("lw_enable", {31'b0, bus.enable_MEM_WB}, 1);
        chk("lw_load",   bus.dmemload_MEM,           32'hDEADBEEF);
        chk("lw_addr",   bus.dmemaddr,               32'h100);
        @(negedge CLK); clear_inputs(); #2;
        chk("lw_ren_off", {31'b0, bus.dmemREN}, 0);
        chk("lw_cnt",     bus.mem_stall_cnt,    0);

        // SW miss, dhit three cycles late
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus.dWEN_EX_MEM = 1; bus.result_EX_MEM = 32'h200; bus.dmemstore_EX_MEM = 32'hCAFE0001;
            bus.dhit = (i == 3);
            #2;
            chk("sw_wen",    {31'b0, bus.dmemWEN},       1);
            chk("sw_stall",  {31'b0, bus.stall_mem},     (i < 3) ? 1 : 0);
            chk("sw_flush",  {31'b0, bus.flush_MEM_WB},  (i < 3) ? 1 : 0);
            chk("sw_enable", {31'b0, bus.enable_MEM_WB}, 1);
        end
        chk("sw_store", bus.dmemstore, 32'hCAFE0001);
        @(negedge CLK); clear_inputs(); #2;
        chk("sw_wen_off", {31'b0, bus.dmemWEN}, 0);
        chk("sw_cnt",     bus.mem_stall_cnt,    3);

        // LL hit then SC success then repeated SC failure
        @(negedge CLK);
        bus.dREN_EX_MEM = 1; bus.datomic_EX_MEM = 1; bus.result_EX_MEM = 32'h300;
        bus.dhit = 1; bus.dmemload = 32'h0000AAAA;
        #2;
        chk("ll_ren",  {31'b0, bus.dmemREN}, 1);
        chk("ll_load", bus.dmemload_MEM,     32'h0000AAAA);
        @(negedge CLK);
        bus.dREN_EX_MEM = 0; bus.dWEN_EX_MEM = 1; bus.dmemstore_EX_MEM = 32'h5;
        #2;
        chk("ll_link",   {31'b0, bus.link_valid}, 1);
        chk("ll_laddr",  bus.link_addr,           32'h300);
        chk("sc_wen",    {31'b0, bus.dmemWEN},    1);
        chk("sc_result", bus.dmemload_MEM,        1);
        @(negedge CLK); #2;
        chk("sc_link_clr", {31'b0, bus.link_valid},    0);
        chk("sc2_wen",     {31'b0, bus.dmemWEN},       0);
        chk("sc2_result",  bus.dmemload_MEM,           0);
        chk("sc2_stall",   {31'b0, bus.stall_mem},     0);
        chk("sc2_enable",  {31'b0, bus.enable_MEM_WB}, 1);

        // LL then snoop on another byte of the same word
        @(negedge CLK); clear_inputs();
        bus.dREN_EX_MEM = 1; bus.datomic_EX_MEM = 1; bus.result_EX_MEM = 32'h300; bus.dhit = 1;
        @(negedge CLK); clear_inputs(); bus.ccinv = 1; bus.ccsnoopaddr = 32'h302;
        #2;
        chk("inv_pre", {31'b0, bus.link_valid}, 1);
        @(negedge CLK); clear_inputs(); #2;
        chk("inv_clr", {31'b0, bus.link_valid}, 0);

        // LL completing alongside a matching invalidate keeps the link
        @(negedge CLK);
        bus.dREN_EX_MEM = 1; bus.datomic_EX_MEM = 1; bus.result_EX_MEM = 32'h300; bus.dhit = 1;
        bus.ccinv = 1; bus.ccsnoopaddr = 32'h300;
        @(negedge CLK); clear_inputs(); #2;
        chk("ll_inv_win", {31'b0, bus.link_valid}, 1);

        // plain stores: other word keeps link, same word clears it
        @(negedge CLK); bus.dWEN_EX_MEM = 1; bus.result_EX_MEM = 32'h304; bus.dhit = 1;
        @(negedge CLK); bus.result_EX_MEM = 32'h302; #2;
        chk("sw_other_word", {31'b0, bus.link_valid}, 1);
        @(negedge CLK); clear_inputs(); #2;
        chk("sw_same_word", {31'b0, bus.link_valid}, 0);

        // LW miss, then dhit under a two-cycle external stall
        @(negedge CLK);
        bus.dREN_EX_MEM = 1; bus.result_EX_MEM = 32'h400; #2;
        chk("hold_miss", {31'b0, bus.stall_mem}, 1);
        @(negedge CLK); bus.dhit = 1; bus.stall_ext = 1; bus.dmemload = 32'h1234; #2;
        chk("hold_ren1",   {31'b0, bus.dmemREN},       1);
        chk("hold_stall1", {31'b0, bus.stall_mem},     0);
        chk("hold_en1",    {31'b0, bus.enable_MEM_WB}, 0);
        chk("hold_load1",  bus.dmemload_MEM,           32'h1234);
        @(negedge CLK); bus.dhit = 0; bus.dmemload = 32'hFFFFFFFF; #2;
        chk("hold_ren2",   {31'b0, bus.dmemREN},       0);
        chk("hold_stall2", {31'b0, bus.stall_mem},     0);
        chk("hold_en2",    {31'b0, bus.enable_MEM_WB}, 0);
        chk("hold_load2",  bus.dmemload_MEM,           32'h1234);
        @(negedge CLK); bus.stall_ext = 0; #2;
        chk("hold_ren3",  {31'b0, bus.dmemREN},       0);
        chk("hold_en3",   {31'b0, bus.enable_MEM_WB}, 1);
        chk("hold_load3", bus.dmemload_MEM,           32'h1234);
        @(negedge CLK); clear_inputs(); #2;
        chk("hold_cnt", bus.mem_stall_cnt, 4);

        // reset while waiting on a miss
        @(negedge CLK);
        bus.dREN_EX_MEM = 1; bus.datomic_EX_MEM = 1; bus.result_EX_MEM = 32'h700; bus.dhit = 1;
        @(negedge CLK); bus.datomic_EX_MEM = 0; bus.result_EX_MEM = 32'h500; bus.dhit = 0; #2;
        chk("wrst_link", {31'b0, bus.link_valid}, 1);
        chk("wrst_miss", {31'b0, bus.stall_mem},  1);
        @(negedge CLK); RST = 1; #2;
        chk("wrst_ren",   {31'b0, bus.dmemREN},   0);
        chk("wrst_stall", {31'b0, bus.stall_mem}, 0);
        chk("wrst_cnt5",  bus.mem_stall_cnt,      5);
        @(negedge CLK); RST = 0; clear_inputs(); #2;
        chk("wrst_ren_after",  {31'b0, bus.dmemREN},    0);
        chk("wrst_link_after", {31'b0, bus.link_valid}, 0);
        chk("wrst_cnt_after",  bus.mem_stall_cnt,       0);

        // 4-bit counter saturation on the second instance
        @(negedge CLK); bus4.dREN_EX_MEM = 1; bus4.result_EX_MEM = 32'h600;
        repeat (14) @(negedge CLK);
        #2;
        chk("sat_cnt14", {28'b0, bus4.mem_stall_cnt}, 14);
        repeat (6) @(negedge CLK);
        #2;
        chk("sat_cnt20", {28'b0, bus4.mem_stall_cnt}, 15);
        chk("sat_stall", {31'b0, bus4.stall_mem},     1);
        @(negedge CLK); clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
